// File: rtl/park_gate_ctrl.sv
// park_gate_ctrl: single-lane barrier controller with entry/exit arbitration and occupancy count.
// Optional build macro PARK_PASS_TIMEOUT_EN: abandon WAIT_PASS after PASS_TMO cycles without a pass.
module park_gate_ctrl #(
  parameter int CAPACITY = 12,
  parameter int CNT_W    = 4,
  parameter int OPEN_CYC = 4,
  parameter int PASS_TMO = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_in,
  input  logic             req_out,
  input  logic             pass,
  output logic             gate_open,
  output logic             busy,
  output logic             dir,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             deny,
  output logic             timeout
);

  // state     | meaning
  // IDLE      | barrier down, arbitrating entry/exit requests
  // OPENING   | barrier rising for OPEN_CYC cycles
  // WAIT_PASS | barrier up, waiting for the car to clear
  // CLOSING   | barrier lowering for OPEN_CYC cycles
  typedef enum logic [1:0] {IDLE, OPENING, WAIT_PASS, CLOSING} state_t;

  localparam int TMR_MAX = (OPEN_CYC > PASS_TMO) ? OPEN_CYC : PASS_TMO;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [CNT_W-1:0] CAP     = CNT_W'(CAPACITY);
  localparam logic [TMR_W-1:0] OPEN_LD = TMR_W'(OPEN_CYC - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;
  logic             dir_q, dir_d;
  logic             last_dir_q, last_dir_d;
  logic             ent_ok, ex_ok;

`ifdef PARK_PASS_TIMEOUT_EN
  localparam logic [TMR_W-1:0] PASS_LD = TMR_W'(PASS_TMO - 1);
  logic tmo_q, tmo_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      dir_q      <= 1'b0;
      last_dir_q <= 1'b1;
`ifdef PARK_PASS_TIMEOUT_EN
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      count_q    <= count_d;
      full_q     <= (count_d == CAP);
      dir_q      <= dir_d;
      last_dir_q <= last_dir_d;
`ifdef PARK_PASS_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    count_d    = count_q;
    dir_d      = dir_q;
    last_dir_d = last_dir_q;
`ifdef PARK_PASS_TIMEOUT_EN
    tmo_d      = 1'b0;
`endif
    // an exit request on an empty park is a sensor fault and never eligible
    ent_ok = req_in && (count_q < CAP);
    ex_ok  = req_out && (count_q != '0);
    unique case (state_q)
      IDLE: begin
        if (ent_ok || ex_ok) begin
          dir_d      = (ent_ok && ex_ok) ? ~last_dir_q : ex_ok;
          last_dir_d = dir_d;
          tmr_d      = OPEN_LD;
          state_d    = OPENING;
        end
      end
      OPENING: begin
        if (tmr_q == '0) begin
          state_d = WAIT_PASS;
`ifdef PARK_PASS_TIMEOUT_EN
          tmr_d   = PASS_LD;
`endif
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      WAIT_PASS: begin
        if (pass) begin
          if (dir_q) count_d = (count_q != '0) ? count_q - 1'b1 : count_q;
          else       count_d = (count_q < CAP) ? count_q + 1'b1 : count_q;
          tmr_d   = OPEN_LD;
          state_d = CLOSING;
        end
`ifdef PARK_PASS_TIMEOUT_EN
        else if (tmr_q == '0) begin
          tmo_d   = 1'b1;
          tmr_d   = OPEN_LD;
          state_d = CLOSING;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end
      CLOSING: begin
        if (tmr_q == '0) state_d = IDLE;
        else             tmr_d   = tmr_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gate_open = (state_q == OPENING) || (state_q == WAIT_PASS);
  assign busy      = (state_q != IDLE);
  assign dir       = dir_q;
  assign count     = count_q;
  assign full      = full_q;
  assign deny      = !rst && (state_q == IDLE) && req_in && full_q;
`ifdef PARK_PASS_TIMEOUT_EN
  assign timeout   = tmo_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_park_gate_ctrl.sv
// Bench for park_gate_ctrl: arbitration vector table, hand-written corner sequences,
// and randomized traffic compared every cycle against a transaction-age reference model.
module tb_park_gate_ctrl;
  localparam int CAP      = 12;
  localparam int CNT_W    = 4;
  localparam int OPEN_CYC = 4;
  localparam int PASS_TMO = 16;

  logic clk, rst, req_in, req_out, pass;
  logic gate_open, busy, dir, full, deny, timeout;
  logic [CNT_W-1:0] count;

  park_gate_ctrl #(.CAPACITY(CAP), .CNT_W(CNT_W), .OPEN_CYC(OPEN_CYC), .PASS_TMO(PASS_TMO)) dut (
    .clk(clk), .rst(rst), .req_in(req_in), .req_out(req_out), .pass(pass),
    .gate_open(gate_open), .busy(busy), .dir(dir), .count(count),
    .full(full), .deny(deny), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string n, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: a transaction is described by its age in cycles since the grant
  // and the age at which closing began (0 while the barrier is still up).
  int m_cnt, m_age, m_close;
  bit m_act, m_dir, m_last, m_tmo, m_ent, m_ex;

  always @(posedge clk) begin
    m_tmo = 1'b0;
    if (rst) begin
      m_cnt = 0; m_act = 0; m_age = 0; m_close = 0; m_dir = 0; m_last = 1;
    end else if (!m_act) begin
      m_ent = req_in && (m_cnt < CAP);
      m_ex  = req_out && (m_cnt > 0);
      if (m_ent || m_ex) begin
        m_dir = (m_ent && m_ex) ? !m_last : m_ex;
        m_last = m_dir; m_act = 1; m_age = 1; m_close = 0;
      end
    end else begin
      if (m_close == 0 && m_age > OPEN_CYC) begin
        if (pass) begin
          if (m_dir) m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
          else       m_cnt = (m_cnt < CAP) ? m_cnt + 1 : CAP;
          m_close = m_age + 1;
        end
`ifdef PARK_PASS_TIMEOUT_EN
        else if (m_age == OPEN_CYC + PASS_TMO) begin
          m_tmo = 1'b1;
          m_close = m_age + 1;
        end
`endif
      end
      m_age++;
      if (m_close != 0 && m_age == m_close + OPEN_CYC) m_act = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_gate_open", gate_open, m_act && m_close == 0);
      check("m_busy", busy, m_act);
      check("m_dir", dir, m_dir);
      check("m_count", int'(count), m_cnt);
      check("m_full", full, m_cnt == CAP);
      check("m_deny", deny, !rst && !m_act && req_in && m_cnt == CAP);
      check("m_timeout", timeout, m_tmo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();
    rst = 1; req_in = 0; req_out = 0; pass = 0;
    tick();
    rst = 0;
  endtask

  task automatic txn(input bit d);
    if (d) req_out = 1; else req_in = 1;
    tick();
    req_in = 0; req_out = 0;
    repeat (OPEN_CYC) tick();
    pass = 1; tick(); pass = 0;
    repeat (OPEN_CYC) tick();
  endtask

  task automatic fill(input int n);
    repeat (n) txn(1'b0);
  endtask

  typedef struct {
    int cnt; bit ri; bit ro; bit last_exit;
    bit exp_deny; bit exp_busy; bit exp_dir;
  } vec_t;
  vec_t vt[10];

  initial begin
    rst = 1; req_in = 0; req_out = 0; pass = 0;
    vt[0] = '{0,  1, 0, 0, 0, 1, 0};
    vt[1] = '{0,  0, 1, 0, 0, 0, 0};
    vt[2] = '{0,  1, 1, 0, 0, 1, 0};
    vt[3] = '{3,  1, 1, 0, 0, 1, 1};
    vt[4] = '{3,  1, 1, 1, 0, 1, 0};
    vt[5] = '{12, 1, 0, 0, 1, 0, 0};
    vt[6] = '{12, 1, 1, 0, 1, 1, 1};
    vt[7] = '{12, 0, 1, 0, 0, 1, 1};
    vt[8] = '{5,  0, 0, 0, 0, 0, 0};
    vt[9] = '{11, 1, 0, 0, 0, 1, 0};
    do_rst();
    chk_en = 1;
    check("rst_gate_open", gate_open, 0);
    check("rst_busy", busy, 0);
    check("rst_dir", dir, 0);
    check("rst_count", int'(count), 0);
    check("rst_full", full, 0);

    // basic entry with latency
    req_in = 1; tick(); req_in = 0;
    check("t1_busy", busy, 1); check("t1_gate", gate_open, 1); check("t1_dir", dir, 0);
    repeat (OPEN_CYC) tick();
    check("t1_wait_gate", gate_open, 1);
    pass = 1; tick(); pass = 0;
    check("t1_count", int'(count), 1); check("t1_gate_closed", gate_open, 0); check("t1_busy_cl", busy, 1);
    repeat (OPEN_CYC - 1) tick();
    check("t1_busy_last", busy, 1);
    tick();
    check("t1_idle", busy, 0);

    // arbitration vector table
    for (int i = 0; i < 10; i++) begin
      do_rst();
      if (vt[i].last_exit) begin fill(vt[i].cnt + 1); txn(1'b1); end
      else fill(vt[i].cnt);
      req_in = vt[i].ri; req_out = vt[i].ro;
      #1;
      check($sformatf("vec%0d_deny", i), deny, vt[i].exp_deny);
      tick();
      check($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
      if (vt[i].exp_busy) check($sformatf("vec%0d_dir", i), dir, vt[i].exp_dir);
      req_in = 0; req_out = 0;
    end

    // full park: deny, then exit granted
    do_rst(); fill(CAP);
    check("f_full", full, 1);
    req_in = 1; #1;
    check("f_deny", deny, 1);
    tick();
    check("f_nogrant", busy, 0);
    req_out = 1; tick();
    check("f_exit_busy", busy, 1); check("f_exit_dir", dir, 1); check("f_deny_busy", deny, 0);
    req_out = 0;
    repeat (OPEN_CYC) tick();
    pass = 1; tick(); pass = 0;
    check("f_count", int'(count), CAP - 1); check("f_full_drop", full, 0);
    repeat (OPEN_CYC) tick();
    check("f_deny_idle", deny, 0);
    tick();
    check("f_entry_dir", dir, 0); check("f_entry_busy", busy, 1);
    req_in = 0;

    // alternation at count 5 with last grant an exit
    do_rst(); fill(6); txn(1'b1);
    req_in = 1; req_out = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("alt%0d_dir", k), dir, (k == 1) ? 1 : 0);
      repeat (OPEN_CYC) tick();
      pass = 1; tick(); pass = 0;
      repeat (OPEN_CYC) tick();
    end
    req_in = 0; req_out = 0;
    check("alt_count", int'(count), 6);

    // exit fault on empty park, pass ignored in OPENING and CLOSING
    do_rst();
    req_out = 1; repeat (3) tick();
    check("fault_busy", busy, 0);
    req_out = 0; req_in = 1; tick(); req_in = 0;
    pass = 1; tick(); pass = 0;
    check("ign_open_count", int'(count), 0); check("ign_open_gate", gate_open, 1);
    repeat (OPEN_CYC - 1) tick();
    pass = 1; tick(); pass = 0;
    check("pass_count", int'(count), 1);
    pass = 1; tick(); pass = 0;
    check("ign_close_count", int'(count), 1);
    repeat (OPEN_CYC) tick();
    check("ign_idle", busy, 0);

    // reset during WAIT_PASS with coincident pass
    do_rst(); fill(7);
    req_in = 1; tick(); req_in = 0;
    repeat (OPEN_CYC) tick();
    check("r_gate_pre", gate_open, 1);
    rst = 1; pass = 1; tick(); rst = 0; pass = 0;
    check("r_gate", gate_open, 0); check("r_busy", busy, 0); check("r_count", int'(count), 0);

    // wait-for-pass timeout behaviour
    do_rst(); fill(2);
    req_in = 1; tick(); req_in = 0;
    repeat (OPEN_CYC) tick();
`ifdef PARK_PASS_TIMEOUT_EN
    repeat (PASS_TMO - 1) tick();
    check("tmo_gate_pre", gate_open, 1); check("tmo_pre", timeout, 0);
    tick();
    check("tmo_pulse", timeout, 1); check("tmo_gate", gate_open, 0); check("tmo_count", int'(count), 2);
    tick();
    check("tmo_pulse_end", timeout, 0);
    repeat (OPEN_CYC - 1) tick();
    check("tmo_idle", busy, 0);
`else
    repeat (100) tick();
    check("notmo_gate", gate_open, 1); check("notmo_timeout", timeout, 0);
    pass = 1; tick(); pass = 0;
    check("notmo_count", int'(count), 3);
    repeat (OPEN_CYC) tick();
`endif

    // randomized traffic against the model
    do_rst();
    for (int i = 0; i < 4000; i++) begin
      int pin;
      pin = ((i / 500) % 2 == 1) ? 80 : 30;
      req_in  = ($urandom_range(99) < pin);
      req_out = ($urandom_range(99) < (100 - pin));
      pass    = ($urandom_range(5) == 0);
      rst     = ($urandom_range(299) == 0);
      tick();
    end
    rst = 0; req_in = 0; req_out = 0; pass = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
